// File: rtl/hwag_cap_cond.sv
// rtl/hwag_cap_cond.sv - crank-sensor input conditioner: sync, glitch filter, tooth period capture and plausibility check
// Feeds hwag with filtered level, accepted-edge strobe, measured period and error status.
module hwag_cap_cond #(
   parameter int PW = 24,
   parameter int FW = 8
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          cap_in,
   input  logic          edge_sel,
   input  logic [FW-1:0] flt_len,
   input  logic [PW-1:0] cap_min,
   input  logic [PW-1:0] cap_max,
   output logic          cap_out,
   output logic          cap_edge,
   output logic [PW-1:0] cap_period,
   output logic          cap_valid,
   output logic          err_short,
   output logic          err_long,
   output logic          cap_stall,
   output logic          cap_run
);

   typedef enum logic {IDLE, RUN} state_t;

   logic          sync1_q, sync2_q;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          cap_out_q, cap_out_d, cap_prev_q;
   logic [PW-1:0] pcnt_q, pcnt_inc;
   logic [PW:0]   p_ext;
   logic [PW-1:0] period_p;
   logic          pcnt_max, act_edge;
   state_t        state_q;
   logic          edge_q, valid_q, short_q, long_q, stall_q;
   logic [PW-1:0] period_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         fcnt_q     <= '0;
         cap_out_q  <= 1'b0;
         cap_prev_q <= 1'b0;
      end else begin
         sync1_q    <= cap_in;
         sync2_q    <= sync1_q;
         fcnt_q     <= fcnt_d;
         cap_out_q  <= cap_out_d;
         cap_prev_q <= cap_out_q;
      end
   end

   // The synchronised level must differ from cap_out for flt_len+1 consecutive cycles to be taken.
   always_comb begin
      fcnt_d    = fcnt_q;
      cap_out_d = cap_out_q;
      if (sync2_q == cap_out_q) begin
         fcnt_d = '0;
      end else if (fcnt_q == flt_len) begin
         cap_out_d = sync2_q;
         fcnt_d    = '0;
      end else begin
         fcnt_d = fcnt_q + 1'b1;
      end
   end

   assign act_edge = (cap_out_q != cap_prev_q) && (cap_out_q == ~edge_sel);
   assign pcnt_max = (pcnt_q == '1);
   assign pcnt_inc = pcnt_max ? pcnt_q : pcnt_q + 1'b1;
   assign p_ext    = {1'b0, pcnt_q} + 1'b1;
   assign period_p = p_ext[PW] ? '1 : p_ext[PW-1:0];

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= IDLE;
         pcnt_q   <= '0;
         edge_q   <= 1'b0;
         valid_q  <= 1'b0;
         short_q  <= 1'b0;
         long_q   <= 1'b0;
         stall_q  <= 1'b0;
         period_q <= '0;
      end else begin
         edge_q  <= 1'b0;
         valid_q <= 1'b0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
         pcnt_q  <= pcnt_inc;
         case (state_q)
            IDLE: begin
               // First edge only establishes the reference point; there is no period yet.
               if (act_edge) begin
                  edge_q  <= 1'b1;
                  pcnt_q  <= '0;
                  stall_q <= 1'b0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (act_edge && period_p >= cap_min) begin
                  edge_q   <= 1'b1;
                  valid_q  <= 1'b1;
                  period_q <= period_p;
                  pcnt_q   <= '0;
                  stall_q  <= 1'b0;
                  long_q   <= (period_p > cap_max);
               end else begin
                  if (act_edge) short_q <= 1'b1;
                  if (period_p > cap_max) stall_q <= 1'b1;
                  if (pcnt_max) state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cap_out    = cap_out_q;
   assign cap_edge   = edge_q;
   assign cap_valid  = valid_q;
   assign cap_period = period_q;
   assign err_short  = short_q;
   assign err_long   = long_q;
   assign cap_stall  = stall_q;
   assign cap_run    = (state_q == RUN);

endmodule

// File: tb/tb_hwag_cap_cond.sv
// tb/tb_hwag_cap_cond.sv - scoreboard bench for hwag_cap_cond with directed tooth patterns
module tb_hwag_cap_cond;
   localparam int PW = 8;
   localparam int FW = 8;
   localparam int B  = 100;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic          cap_in = 1'b0;
   logic          edge_sel = 1'b0;
   logic [FW-1:0] flt_len = '0;
   logic [PW-1:0] cap_min = 8'd5;
   logic [PW-1:0] cap_max = 8'd100;
   logic          cap_out, cap_edge, cap_valid, err_short, err_long, cap_stall, cap_run;
   logic [PW-1:0] cap_period;

   hwag_cap_cond #(.PW(PW), .FW(FW)) dut (
      .clk(clk), .nrst(nrst), .cap_in(cap_in), .edge_sel(edge_sel), .flt_len(flt_len),
      .cap_min(cap_min), .cap_max(cap_max), .cap_out(cap_out), .cap_edge(cap_edge),
      .cap_period(cap_period), .cap_valid(cap_valid), .err_short(err_short),
      .err_long(err_long), .cap_stall(cap_stall), .cap_run(cap_run)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            at;
      bit            e;
      bit            v;
      bit            s;
      bit            l;
      logic [PW-1:0] per;
   } exp_t;

   exp_t sb[$];
   int   n_run  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every strobe cycle consumes one expected event.
   always @(negedge clk) begin
      if (cap_edge || cap_valid || err_short || err_long) begin
         if (sb.size() == 0) begin
            chk("unexpected_strobe", {28'd0, cap_edge, cap_valid, err_short, err_long}, 0);
         end else begin
            exp_t x;
            x = sb.pop_front();
            chk("event_cycle", cyc, x.at);
            chk("cap_edge", cap_edge, x.e);
            chk("cap_valid", cap_valid, x.v);
            chk("err_short", err_short, x.s);
            chk("err_long", err_long, x.l);
            chk("cap_period", cap_period, x.per);
         end
      end
   end

   task automatic to_cyc(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic at_neg(input int t);
      while (cyc < t || clk) @(negedge clk);
   endtask

   task automatic pulse(input int t, input bit e, input bit v, input bit s, input bit l,
                        input int per, input int lat);
      to_cyc(t);
      cap_in = 1'b1;
      sb.push_back('{at: t + lat, e: e, v: v, s: s, l: l, per: per[PW-1:0]});
      @(posedge clk);
      #1 cap_in = 1'b0;
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_cap_out"}, cap_out, 0);
      chk({name, "_cap_edge"}, cap_edge, 0);
      chk({name, "_cap_period"}, cap_period, 0);
      chk({name, "_cap_valid"}, cap_valid, 0);
      chk({name, "_err_short"}, err_short, 0);
      chk({name, "_err_long"}, err_long, 0);
      chk({name, "_cap_stall"}, cap_stall, 0);
      chk({name, "_cap_run"}, cap_run, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      @(negedge clk);
      chk_all_zero("reset");
      to_cyc(3);
      nrst = 1'b1;

      // Filter: flt_len=3, a 3-cycle pulse is dropped, a 4-cycle pulse passes after 6 cycles.
      flt_len = 8'd3;
      to_cyc(10);
      cap_in = 1'b1;
      to_cyc(13);
      cap_in = 1'b0;
      for (int c = 10; c <= 20; c++) begin
         at_neg(c);
         chk("flt_short_pulse", cap_out, 0);
      end
      to_cyc(30);
      cap_in = 1'b1;
      sb.push_back('{at: 37, e: 1'b1, v: 1'b0, s: 1'b0, l: 1'b0, per: '0});
      to_cyc(34);
      cap_in = 1'b0;
      at_neg(35);
      chk("flt_rise_early", cap_out, 0);
      at_neg(36);
      chk("flt_rise", cap_out, 1);
      at_neg(38);
      chk("run_after_first", cap_run, 1);
      at_neg(39);
      chk("flt_fall_early", cap_out, 1);
      at_neg(40);
      chk("flt_fall", cap_out, 0);

      to_cyc(50);
      nrst = 1'b0;
      @(posedge clk);
      #1 nrst = 1'b1;
      flt_len = 8'd0;

      // Regular 40-cycle teeth plus a short glitch.
      pulse(B,       1, 0, 0, 0, 0,  4);
      pulse(B + 40,  1, 1, 0, 0, 40, 4);
      pulse(B + 80,  1, 1, 0, 0, 40, 4);
      pulse(B + 83,  0, 0, 1, 0, 40, 4);
      pulse(B + 120, 1, 1, 0, 0, 40, 4);

      // Missing tooth with cap_max=60.
      to_cyc(B + 125);
      cap_max = 8'd60;
      pulse(B + 160, 1, 1, 0, 0, 40, 4);
      pulse(B + 200, 1, 1, 0, 0, 40, 4);
      at_neg(B + 264);
      chk("stall_before", cap_stall, 0);
      at_neg(B + 265);
      chk("stall_set", cap_stall, 1);
      pulse(B + 320, 1, 1, 0, 1, 120, 4);
      at_neg(B + 323);
      chk("stall_held", cap_stall, 1);
      at_neg(B + 324);
      chk("stall_cleared", cap_stall, 0);
      pulse(B + 360, 1, 1, 0, 0, 40, 4);

      // Boundaries: P == cap_min == cap_max accepted; one below min rejected; above max flagged.
      to_cyc(B + 365);
      cap_min = 8'd40;
      cap_max = 8'd40;
      pulse(B + 400, 1, 1, 0, 0, 40, 4);
      pulse(B + 439, 0, 0, 1, 0, 40, 4);
      pulse(B + 480, 1, 1, 0, 1, 80, 4);
      to_cyc(B + 490);
      cap_min = 8'd5;
      cap_max = 8'd100;

      // Saturation: no edges, pcnt hits 255 and the FSM drops to IDLE.
      at_neg(B + 739);
      chk("run_before_sat", cap_run, 1);
      at_neg(B + 740);
      chk("run_after_sat", cap_run, 0);
      chk("stall_at_sat", cap_stall, 1);
      pulse(B + 800, 1, 0, 0, 0, 80, 4);
      at_neg(B + 804);
      chk("stall_after_idle_edge", cap_stall, 0);
      chk("run_after_idle_edge", cap_run, 1);

      // Asynchronous reset mid-period.
      to_cyc(B + 820);
      nrst = 1'b0;
      #1;
      chk_all_zero("midreset");
      @(posedge clk);
      #1 nrst = 1'b1;
      pulse(B + 860, 1, 0, 0, 0, 0,  4);
      pulse(B + 900, 1, 1, 0, 0, 40, 4);

      // Falling-edge selection: the 1-cycle pulse's fall is one cycle after its rise.
      to_cyc(B + 910);
      edge_sel = 1'b1;
      pulse(B + 940, 1, 1, 0, 0, 41, 5);

      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
